// File: rtl/syn_fifo_pkg.sv
// Shared defaults and helper functions for the single-clock FIFO.
// The SYN_FIFO_PARITY_EN build uses even_parity on both write and read paths.
package syn_fifo_pkg;

    localparam int DefaultDataWidth = 8;
    localparam int DefaultAddrWidth = 4;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int ParityMaxWidth = 64;

    // Pointer width for a given depth: one extra MSB separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Even parity bit: the XOR of all data bits.
    function automatic logic even_parity(input logic [ParityMaxWidth-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// Simple dual-port register-array RAM with one write port and one read port.
// REG_READ=1 registers the read port; REG_READ=0 reads it combinationally.
module syn_fifo_mem #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter bit REG_READ   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int Depth = 1 << ADDR_WIDTH;

    // Storage is not reset.
    logic [WIDTH-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (REG_READ) begin : g_reg_read
        logic [WIDTH-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem[raddr];
            end
        end

        assign rdata = rdata_q;
    end else begin : g_comb_read
        logic unused_read_ctrl;

        assign unused_read_ctrl = reset_n ^ re;
        assign rdata            = mem[raddr];
    end

endmodule

// File: rtl/syn_fifo_ctrl.sv
// Parametrised single-clock FIFO: pointers, occupancy, thresholds, sticky errors and
// standard or FWFT read mode. Define SYN_FIFO_PARITY_EN to add a stored parity bit.
module syn_fifo_ctrl
    import syn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DefaultDataWidth,
    parameter int ADDR_WIDTH = DefaultAddrWidth,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
`ifdef SYN_FIFO_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = ptr_width(DEPTH);

    localparam logic [PTR_W-1:0]    PtrOne   = PTR_W'(1);
    localparam logic [ADDR_WIDTH:0] CntOne   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfCnt    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AeCnt    = (ADDR_WIDTH + 1)'(AE_THRESH);

`ifdef SYN_FIFO_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH &&
          DATA_WIDTH > 0 && DATA_WIDTH <= ParityMaxWidth)) begin : g_bad_params
        $fatal(1, "syn_fifo_ctrl: need 0 < AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                wr_acc;
    logic                rd_acc;
    logic [MEM_W-1:0]    mem_wdata;
    logic [MEM_W-1:0]    mem_rdata;

    // Flags come straight from the registered count.
    assign full         = (count_q == DepthCnt);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AfCnt);
    assign almost_empty = (count_q <= AeCnt);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses pre-edge state; reset overrides every request.
    assign wr_acc = reset_n && wr_en && !full;
    assign rd_acc = reset_n && rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // A new error event wins over a simultaneous clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SYN_FIFO_PARITY_EN
    assign mem_wdata = {even_parity(ParityMaxWidth'(wr_data)), wr_data};
`else
    assign mem_wdata = wr_data;
`endif

    syn_fifo_mem #(
        .WIDTH      (MEM_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_READ   (FWFT == 0)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_acc),
        .waddr   (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata   (mem_wdata),
        .re      (rd_acc),
        .raddr   (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata   (mem_rdata)
    );

    assign rd_data = mem_rdata[DATA_WIDTH-1:0];

    if (FWFT != 0) begin : g_fwft
        // The head word is always presented; rd_en acknowledges it.
        assign rd_valid = !empty;
    end else begin : g_std
        logic rd_valid_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
            end
        end

        assign rd_valid = rd_valid_q;
    end

`ifdef SYN_FIFO_PARITY_EN
    // The read-side word already follows rd_valid timing in both modes.
    assign parity_err = rd_valid &&
        (mem_rdata[DATA_WIDTH] != even_parity(ParityMaxWidth'(mem_rdata[DATA_WIDTH-1:0])));
`endif

endmodule

// File: tb/tb_syn_fifo_ctrl.sv
// Scoreboarded bench for syn_fifo_ctrl: a standard-read instance checked through an
// expected-data queue, plus an FWFT instance checked with directed vectors.
module tb_syn_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-read instance
    logic          reset_n, wr_en, rd_en, clr_err;
    logic [DW-1:0] wr_data, rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;
`ifdef SYN_FIFO_PARITY_EN
    logic          parity_err, f_parity_err;
`endif

    // FWFT instance
    logic          f_reset_n, f_wr_en, f_rd_en, f_clr_err;
    logic [DW-1:0] f_wr_data, f_rd_data;
    logic          f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty;
    logic          f_overflow, f_underflow;
    logic [AW:0]   f_count;

    syn_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_THRESH  (DEPTH - 2),
        .AE_THRESH  (2),
        .FWFT       (0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
`ifdef SYN_FIFO_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    syn_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_THRESH  (DEPTH - 2),
        .AE_THRESH  (2),
        .FWFT       (1)
    ) dut_fwft (
        .clk          (clk),
        .reset_n      (f_reset_n),
        .wr_en        (f_wr_en),
        .wr_data      (f_wr_data),
        .rd_en        (f_rd_en),
        .rd_data      (f_rd_data),
        .rd_valid     (f_rd_valid),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_almost_full),
        .almost_empty (f_almost_empty),
        .count        (f_count),
        .overflow     (f_overflow),
        .underflow    (f_underflow),
        .clr_err      (f_clr_err)
`ifdef SYN_FIFO_PARITY_EN
        ,
        .parity_err   (f_parity_err)
`endif
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] mon_exp;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input bit we, input logic [DW-1:0] wd, input bit re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    // Monitor: every presented word must match the head of the expected queue.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got rd_data 0x%0h with nothing expected at %0t",
                         rd_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", int'(rd_data), int'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clr_err   = 1'b0;
        wr_data   = '0;
        f_reset_n = 1'b0;
        f_wr_en   = 1'b0;
        f_rd_en   = 1'b0;
        f_clr_err = 1'b0;
        f_wr_data = '0;
        repeat (2) step();
        reset_n   = 1'b1;
        f_reset_n = 1'b1;

        // Reset state
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b1, DW'(i), 1'b0);
            chk("fill_count", int'(count), i + 1);
            chk("fill_almost_full", int'(almost_full), int'(i + 1 >= 14));
            chk("fill_almost_empty", int'(almost_empty), int'(i + 1 <= 2));
            chk("fill_full", int'(full), int'(i + 1 == 16));
        end
        op(1'b1, 8'hFF, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        pulse_clr();
        chk("ovf_clr", int'(overflow), 0);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(DW'(i));
            op(1'b0, '0, 1'b1);
            chk("drain_count", int'(count), 15 - i);
            chk("drain_rd_valid", int'(rd_valid), 1);
            chk("drain_almost_empty", int'(almost_empty), int'(15 - i <= 2));
        end
        chk("drain_empty", int'(empty), 1);
        op(1'b0, '0, 1'b1);
        chk("unf_set", int'(underflow), 1);
        chk("unf_rd_valid", int'(rd_valid), 0);
        chk("unf_count", int'(count), 0);
        pulse_clr();
        chk("unf_clr", int'(underflow), 0);
        // Set beats a simultaneous clear
        clr_err = 1'b1;
        op(1'b0, '0, 1'b1);
        clr_err = 1'b0;
        chk("unf_set_wins", int'(underflow), 1);
        pulse_clr();
        chk("unf_clr2", int'(underflow), 0);

        // Refill, then read+write at full: only the read is taken
        for (int i = 0; i < DEPTH; i++) op(1'b1, 8'h10 + DW'(i), 1'b0);
        exp_q.push_back(8'h10);
        op(1'b1, 8'hEE, 1'b1);
        chk("full_rw_count", int'(count), 15);
        chk("full_rw_overflow", int'(overflow), 1);
        chk("full_rw_full", int'(full), 0);
        pulse_clr();
        for (int i = 1; i < 8; i++) begin
            exp_q.push_back(8'h10 + DW'(i));
            op(1'b0, '0, 1'b1);
        end
        chk("mid_count", int'(count), 8);

        // 40 simultaneous read+write at count 8, across pointer wrap
        for (int i = 8; i < 16; i++) model_q.push_back(8'h10 + DW'(i));
        for (int k = 0; k < 40; k++) begin
            exp_q.push_back(model_q.pop_front());
            model_q.push_back(8'h40 + DW'(k));
            op(1'b1, 8'h40 + DW'(k), 1'b1);
            chk("rw_count", int'(count), 8);
        end
        chk("rw_no_errors", int'({overflow, underflow}), 0);
        while (model_q.size() > 0) begin
            exp_q.push_back(model_q.pop_front());
            op(1'b0, '0, 1'b1);
        end
        chk("wrap_empty", int'(empty), 1);
        op(1'b0, '0, 1'b0);
        chk("wrap_scoreboard_drained", exp_q.size(), 0);

        // Mid-operation reset with 10 words stored and a pending underflow
        op(1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) op(1'b1, 8'h60 + DW'(i), 1'b0);
        chk("pre_rst_count", int'(count), 10);
        chk("pre_rst_underflow", int'(underflow), 1);
        reset_n = 1'b0;
        op(1'b1, 8'h99, 1'b0);
        reset_n = 1'b1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_errors", int'({overflow, underflow}), 0);
        chk("mid_rst_rd_valid", int'(rd_valid), 0);
        op(1'b1, 8'h77, 1'b0);
        exp_q.push_back(8'h77);
        op(1'b0, '0, 1'b1);
        op(1'b0, '0, 1'b0);
        chk("post_rst_rd_valid_low", int'(rd_valid), 0);
        chk("post_rst_rd_data_hold", int'(rd_data), 8'h77);
        chk("post_rst_scoreboard_drained", exp_q.size(), 0);

        // FWFT: fall-through and acknowledge
        chk("fwft_rst_valid", int'(f_rd_valid), 0);
        chk("fwft_rst_empty", int'(f_empty), 1);
        f_wr_en   = 1'b1;
        f_wr_data = 8'hA5;
        step();
        f_wr_en = 1'b0;
        chk("fwft_valid", int'(f_rd_valid), 1);
        chk("fwft_data", int'(f_rd_data), 8'hA5);
        chk("fwft_count", int'(f_count), 1);
        step();
        chk("fwft_hold_valid", int'(f_rd_valid), 1);
        chk("fwft_hold_data", int'(f_rd_data), 8'hA5);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        chk("fwft_pop_valid", int'(f_rd_valid), 0);
        chk("fwft_pop_empty", int'(f_empty), 1);
        f_wr_en   = 1'b1;
        f_wr_data = 8'h3C;
        step();
        f_wr_data = 8'hC3;
        step();
        f_wr_en = 1'b0;
        chk("fwft_head0", int'(f_rd_data), 8'h3C);
        f_rd_en = 1'b1;
        step();
        chk("fwft_head1", int'(f_rd_data), 8'hC3);
        chk("fwft_head1_valid", int'(f_rd_valid), 1);
        step();
        f_rd_en = 1'b0;
        chk("fwft_final_valid", int'(f_rd_valid), 0);
        chk("fwft_no_errors", int'({f_overflow, f_underflow}), 0);

`ifdef SYN_FIFO_PARITY_EN
        // Parity: corrupt the stored parity of word 3 (0x33 has even parity 0)
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) op(1'b1, 8'h30 + DW'(k), 1'b0);
        force dut.u_mem.mem[3][DW] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(8'h30 + DW'(k));
            op(1'b0, '0, 1'b1);
            chk("parity_err", int'(parity_err), int'(k == 3));
        end
        release dut.u_mem.mem[3][DW];
        op(1'b0, '0, 1'b0);
        chk("parity_err_idle", int'(parity_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
